// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory-macro side of mem_arbiter.
// The arbiter takes the slave view; the requesters/memory side takes the master view.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_done;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_done;
  logic [DW-1:0] b_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_done, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_done, b_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_done, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_done, b_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory macro.
// One access in flight; reads wait a fixed MEM_LAT cycles before data is captured.
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_e;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_e        state_q;
  logic          owner_q;
  logic          lastOwner_q;
  logic [3:0]    cnt_q;
  logic          aGnt_q, bGnt_q;
  logic          aDone_q, bDone_q;
  logic [DW-1:0] aRdata_q, bRdata_q;
  logic          memEn_q, memWe_q;
  logic [AW-1:0] memAddr_q;
  logic [DW-1:0] memWdata_q;

  logic          anyReq_d;
  logic          pickB_d;

  // Owner encoding: 0 = port A, 1 = port B. On a tie the port that did not go last wins.
  always_comb begin
    anyReq_d = bus.a_req | bus.b_req;
    if (bus.a_req && bus.b_req) pickB_d = ~lastOwner_q;
    else                        pickB_d = bus.b_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastOwner_q <= 1'b1;
      cnt_q       <= 4'd0;
      aGnt_q      <= 1'b0;
      bGnt_q      <= 1'b0;
      aDone_q     <= 1'b0;
      bDone_q     <= 1'b0;
      aRdata_q    <= '0;
      bRdata_q    <= '0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            owner_q    <= pickB_d;
            memWe_q    <= pickB_d ? bus.b_we    : bus.a_we;
            memAddr_q  <= pickB_d ? bus.b_addr  : bus.a_addr;
            memWdata_q <= pickB_d ? bus.b_wdata : bus.a_wdata;
            memEn_q    <= 1'b1;
            aGnt_q     <= ~pickB_d;
            bGnt_q     <= pickB_d;
            state_q    <= ACC;
          end
        end
        ACC: begin
          memEn_q <= 1'b0;
          memWe_q <= 1'b0;
          aGnt_q  <= 1'b0;
          bGnt_q  <= 1'b0;
          if (memWe_q) begin
            aDone_q <= ~owner_q;
            bDone_q <= owner_q;
            state_q <= DONE;
          end else begin
            cnt_q   <= LAT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Last wait cycle: memory data is valid now.
          if (cnt_q == 4'd1) begin
            if (owner_q) bRdata_q <= bus.mem_rdata;
            else         aRdata_q <= bus.mem_rdata;
            aDone_q <= ~owner_q;
            bDone_q <= owner_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          aDone_q     <= 1'b0;
          bDone_q     <= 1'b0;
          lastOwner_q <= owner_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_gnt     = aGnt_q;
  assign bus.b_gnt     = bGnt_q;
  assign bus.a_done    = aDone_q;
  assign bus.b_done    = bDone_q;
  assign bus.a_rdata   = aRdata_q;
  assign bus.b_rdata   = bRdata_q;
  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-timestamp model and a memory that answers after MEM_LAT cycles.
module tb_mem_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Memory macro: writes land on the strobe, read data shows up LAT cycles later, junk otherwise.
  logic [DW-1:0] memArr [256];
  logic [DW-1:0] pendData;
  int            sinceRd = -1;

  always @(negedge clk) begin
    if (!rst_n) sinceRd = -1;
    else if (bus.mem_en) begin
      if (bus.mem_we) memArr[bus.mem_addr] = bus.mem_wdata;
      else begin
        pendData = memArr[bus.mem_addr];
        sinceRd  = 0;
      end
    end else if (sinceRd >= 0) sinceRd++;
    bus.mem_rdata = (sinceRd == LAT) ? pendData : DW'($urandom);
    if (sinceRd == LAT) sinceRd = -1;
  end

  // Requester-side stimulus, index 0 = port A, 1 = port B.
  bit            reqV   [2];
  bit            weV    [2];
  logic [AW-1:0] addrV  [2];
  logic [DW-1:0] wdataV [2];
  bit            holdV  [2];
  bit            randMode = 0;

  // Reference model: one transaction at a time, described by the cycles it touches.
  logic [DW-1:0] refMem [256];
  int            cyc = 0;
  bit            busy = 0;
  int            gntCyc, doneCyc, idleCyc = 0;
  bit            own, lastOwn = 1, curWe;
  logic [DW-1:0] curRd, expWdata;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expRd [2];

  int gntOrder [$];
  int lastADone = -100;
  int lastBGnt  = -100;

  task automatic applyStimulus();
    bus.a_req   = reqV[0];
    bus.a_we    = weV[0];
    bus.a_addr  = addrV[0];
    bus.a_wdata = wdataV[0];
    bus.b_req   = reqV[1];
    bus.b_we    = weV[1];
    bus.b_addr  = addrV[1];
    bus.b_wdata = wdataV[1];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a_gnt"},     32'(bus.a_gnt),     0);
    checkOutput({tag, "_b_gnt"},     32'(bus.b_gnt),     0);
    checkOutput({tag, "_a_done"},    32'(bus.a_done),    0);
    checkOutput({tag, "_b_done"},    32'(bus.b_done),    0);
    checkOutput({tag, "_a_rdata"},   32'(bus.a_rdata),   0);
    checkOutput({tag, "_b_rdata"},   32'(bus.b_rdata),   0);
    checkOutput({tag, "_mem_en"},    32'(bus.mem_en),    0);
    checkOutput({tag, "_mem_we"},    32'(bus.mem_we),    0);
    checkOutput({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
    checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
  endtask

  task automatic resetModel();
    busy     = 0;
    lastOwn  = 1;
    idleCyc  = 0;
    expRd[0] = '0;
    expRd[1] = '0;
    expAddr  = '0;
    expWdata = '0;
  endtask

  // Called in the second half of a cycle with that cycle's inputs applied.
  task automatic stepCycle();
    bit eg, ed;
    if (!rst_n) resetModel();
    else if (!busy && cyc >= idleCyc && (reqV[0] || reqV[1])) begin
      own      = (reqV[0] && reqV[1]) ? !lastOwn : reqV[1];
      curWe    = weV[own];
      expAddr  = addrV[own];
      expWdata = wdataV[own];
      if (curWe) refMem[expAddr] = wdataV[own];
      else       curRd = refMem[expAddr];
      gntCyc  = cyc + 1;
      doneCyc = curWe ? cyc + 2 : cyc + 2 + LAT;
      idleCyc = doneCyc + 1;
      busy    = 1;
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;

    eg = busy && (cyc == gntCyc);
    ed = busy && (cyc == doneCyc);
    if (ed && !curWe) expRd[own] = curRd;
    checkOutput("a_gnt",     32'(bus.a_gnt),     32'(eg && !own));
    checkOutput("b_gnt",     32'(bus.b_gnt),     32'(eg && own));
    checkOutput("a_done",    32'(bus.a_done),    32'(ed && !own));
    checkOutput("b_done",    32'(bus.b_done),    32'(ed && own));
    checkOutput("mem_en",    32'(bus.mem_en),    32'(eg));
    checkOutput("mem_we",    32'(bus.mem_we),    32'(eg && curWe));
    checkOutput("mem_addr",  32'(bus.mem_addr),  32'(expAddr));
    checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(expWdata));
    checkOutput("a_rdata",   32'(bus.a_rdata),   32'(expRd[0]));
    checkOutput("b_rdata",   32'(bus.b_rdata),   32'(expRd[1]));

    if (bus.a_gnt)  gntOrder.push_back(0);
    if (bus.b_gnt)  begin gntOrder.push_back(1); lastBGnt = cyc; end
    if (bus.a_done) lastADone = cyc;
    if (ed) begin
      busy    = 0;
      lastOwn = own;
    end

    for (int p = 0; p < 2; p++) begin
      if (eg && (own == p[0]) && !holdV[p]) reqV[p] = 0;
      if (randMode) begin
        if (!reqV[p]) begin
          weV[p]    = 1'($urandom);
          addrV[p]  = 8'h40 + AW'($urandom_range(0, 7));
          wdataV[p] = DW'($urandom);
          if ($urandom_range(0, 2) == 0) reqV[p] = 1;
        end else if (!(busy && own == p[0]) && $urandom_range(0, 11) == 0) begin
          reqV[p] = 0;
        end
      end
    end
    applyStimulus();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      memArr[i] = DW'($urandom);
      refMem[i] = memArr[i];
    end
    memArr[8'h10] = 8'h5A;
    refMem[8'h10] = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      reqV[p] = 0; weV[p] = 0; addrV[p] = '0; wdataV[p] = '0; holdV[p] = 0;
    end
    applyStimulus();

    // Reset values.
    repeat (2) @(negedge clk);
    checkAllZero("rst");
    rst_n = 1'b1;
    resetModel();

    // A reads 0x10.
    reqV[0] = 1; weV[0] = 0; addrV[0] = 8'h10;
    applyStimulus();
    repeat (6) stepCycle();
    checkOutput("a_rd_10", 32'(bus.a_rdata), 32'h5A);

    // B writes 0x33 to 0x20, A reads it back.
    reqV[1] = 1; weV[1] = 1; addrV[1] = 8'h20; wdataV[1] = 8'h33;
    applyStimulus();
    repeat (4) stepCycle();
    reqV[0] = 1; weV[0] = 0; addrV[0] = 8'h20;
    applyStimulus();
    repeat (6) stepCycle();
    checkOutput("a_rd_20", 32'(bus.a_rdata), 32'h33);

    // Fresh reset, then both ports hold requests: grants must alternate starting with A.
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    holdV[0] = 1; holdV[1] = 1;
    reqV[0] = 1; weV[0] = 0; addrV[0] = 8'h10;
    reqV[1] = 1; weV[1] = 0; addrV[1] = 8'h20;
    applyStimulus();
    gntOrder.delete();
    for (int i = 0; i < 40; i++) begin
      stepCycle();
      if (gntOrder.size() >= 4) break;
    end
    holdV[0] = 0; holdV[1] = 0;
    reqV[0] = 0; reqV[1] = 0;
    applyStimulus();
    repeat (8) stepCycle();
    checkOutput("tie_count", 32'(gntOrder.size()), 4);
    for (int i = 0; i < gntOrder.size(); i++)
      checkOutput("tie_order", 32'(gntOrder[i]), 32'(i % 2));

    // B rises while A's read is waiting on memory.
    reqV[0] = 1; weV[0] = 0; addrV[0] = 8'h30;
    applyStimulus();
    repeat (2) stepCycle();
    reqV[1] = 1; weV[1] = 1; addrV[1] = 8'h31; wdataV[1] = 8'hC4;
    applyStimulus();
    repeat (10) stepCycle();
    checkOutput("b_gnt_after_a_done", 32'(lastBGnt - lastADone), 2);

    // Reset in the middle of A's read wait.
    reqV[0] = 1; weV[0] = 0; addrV[0] = 8'h10;
    applyStimulus();
    repeat (2) stepCycle();
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_wait");
    reqV[0] = 1; weV[0] = 0; addrV[0] = 8'h20;
    reqV[1] = 1; weV[1] = 0; addrV[1] = 8'h10;
    applyStimulus();
    repeat (3) stepCycle();
    gntOrder.delete();
    rst_n = 1'b1;
    repeat (14) stepCycle();
    checkOutput("rst_first_a", (gntOrder.size() > 0) ? 32'(gntOrder[0]) : 32'd99, 0);

    // Random traffic from both ports.
    randMode = 1;
    repeat (400) stepCycle();
    randMode = 0;
    reqV[0] = 0; reqV[1] = 0;
    applyStimulus();
    repeat (20) stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
